// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern generator: FSM state codes, Control modes,
// checkerboard cell-size selects and the parity helper.
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    WAIT_LINE  = 2'd2,
    ACTIVE     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_HBARS   = 2'd1,
    MODE_VBARS   = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_e;

  localparam logic [1:0] CELL_1PX = 2'd0;
  localparam logic [1:0] CELL_2PX = 2'd1;
  localparam logic [1:0] CELL_4PX = 2'd2;
  localparam logic [1:0] CELL_8PX = 2'd3;

  // Checkerboard parity: bit X of column XOR bit X of row (cell = 2^X pixels).
  function automatic logic cb_parity(input logic [31:0] c, input logic [31:0] r,
                                     input logic [1:0] x);
    logic [31:0] cs;
    logic [31:0] rs;
    cs = c >> x;
    rs = r >> x;
    return cs[0] ^ rs[0];
  endfunction

endpackage

// File: rtl/pattern_timing_gen_pos_counter.sv
// Parameterised wrap counter (0..MAX) with clear, enable and terminal count.
// Also exposes its next value so the parent can align derived flags with it.
module pos_counter #(
  parameter int W   = 10,
  parameter int MAX = 639
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == MAX_V) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign nxt_o = cnt_d;
  assign tc_o  = (cnt_q == MAX_V);

endmodule

// File: rtl/pattern_timing_gen.sv
// Line/frame timing beside the pattern Control FSM: pixel position, line/frame
// end pulses, checkerboard parity and a sticky protocol-violation flag.
module pattern_timing_gen
  import pattern_pkg::*;
#(
  parameter int LINE_LEN    = 640,
  parameter int FRAME_LINES = 480,
  parameter int COL_W       = 10,
  parameter int ROW_W       = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync,
  input  logic             f_sync,
  input  logic             cnt_enb,
  input  logic [1:0]       X,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             active,
  output logic             newLine,
  output logic             endLine,
  output logic             endFrame,
  output logic             cb_phase,
  output logic             sync_err
);

  localparam logic [COL_W-1:0] COL_PRE_LAST = COL_W'(LINE_LEN - 2);

  state_e state_q, state_d;

  logic [COL_W-1:0] col_q, col_nxt;
  logic [ROW_W-1:0] row_q, row_nxt;
  logic             col_tc, row_tc;
  logic             col_clr, col_en, row_clr, row_en;

  logic active_q, active_d;
  logic new_line_q, new_line_d;
  logic end_line_q, end_line_d;
  logic end_frame_q, end_frame_d;
  logic cb_q, cb_d;
  logic err_q, err_d;
  logic pix_new;

  pos_counter #(.W(COL_W), .MAX(LINE_LEN - 1)) u_col (
    .clk   (clk),
    .rst   (rst_n),
    .clr_i (col_clr),
    .en_i  (col_en),
    .cnt_o (col_q),
    .nxt_o (col_nxt),
    .tc_o  (col_tc)
  );

  // Row wraps to 0 on its own after the last line of the frame.
  pos_counter #(.W(ROW_W), .MAX(FRAME_LINES - 1)) u_row (
    .clk   (clk),
    .rst   (rst_n),
    .clr_i (row_clr),
    .en_i  (row_en),
    .cnt_o (row_q),
    .nxt_o (row_nxt),
    .tc_o  (row_tc)
  );

  always_comb begin
    state_d     = state_q;
    col_clr     = 1'b0;
    col_en      = 1'b0;
    row_clr     = 1'b0;
    row_en      = 1'b0;
    active_d    = active_q;
    new_line_d  = 1'b0;
    end_line_d  = 1'b0;
    end_frame_d = 1'b0;
    err_d       = err_q;
    pix_new     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cnt_enb) state_d = WAIT_FRAME;
      end

      WAIT_FRAME: begin
        if (f_sync) begin
          row_clr = 1'b1;
          col_clr = 1'b1;
          state_d = WAIT_LINE;
          if (sync) begin
            active_d   = 1'b1;
            new_line_d = 1'b1;
            pix_new    = 1'b1;
            state_d    = ACTIVE;
          end
        end
      end

      WAIT_LINE: begin
        if (f_sync) begin
          row_clr  = 1'b1;
          col_clr  = 1'b1;
          active_d = 1'b0;
          if (row_q != '0) err_d = 1'b1;
        end
        if (sync) begin
          col_clr    = 1'b1;
          active_d   = 1'b1;
          new_line_d = 1'b1;
          pix_new    = 1'b1;
          state_d    = ACTIVE;
        end
      end

      ACTIVE: begin
        if (f_sync) begin
          // Frame restart wins; a coincident sync then opens row 0 at once.
          row_clr  = 1'b1;
          col_clr  = 1'b1;
          err_d    = 1'b1;
          active_d = 1'b0;
          state_d  = WAIT_LINE;
          if (sync) begin
            active_d   = 1'b1;
            new_line_d = 1'b1;
            pix_new    = 1'b1;
            state_d    = ACTIVE;
          end
        end else if (sync) begin
          col_clr    = 1'b1;
          new_line_d = 1'b1;
          err_d      = 1'b1;
          pix_new    = 1'b1;
        end else if (cnt_enb) begin
          col_en = 1'b1;
          if (col_tc) begin
            active_d = 1'b0;
            row_en   = 1'b1;
            state_d  = row_tc ? WAIT_FRAME : WAIT_LINE;
          end else begin
            pix_new     = 1'b1;
            end_line_d  = (col_q == COL_PRE_LAST);
            end_frame_d = (col_q == COL_PRE_LAST) && row_tc;
          end
        end
      end
    endcase

    // Parity follows the next pixel; during a stall it holds with col/row.
    if (!active_d) begin
      cb_d = 1'b0;
    end else if (pix_new) begin
      cb_d = cb_parity(32'(col_nxt), 32'(row_nxt), X);
    end else begin
      cb_d = cb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      active_q    <= 1'b0;
      new_line_q  <= 1'b0;
      end_line_q  <= 1'b0;
      end_frame_q <= 1'b0;
      cb_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      new_line_q  <= new_line_d;
      end_line_q  <= end_line_d;
      end_frame_q <= end_frame_d;
      cb_q        <= cb_d;
      err_q       <= err_d;
    end
  end

  assign col      = col_q;
  assign row      = row_q;
  assign active   = active_q;
  assign newLine  = new_line_q;
  assign endLine  = end_line_q;
  assign endFrame = end_frame_q;
  assign cb_phase = cb_q;
  assign sync_err = err_q;

endmodule

// File: tb/tb_pattern_timing_gen.sv
// Bench for pattern_timing_gen with a 4-pixel, 2-line frame: vector table driven
// through an expectation queue, plus hand-written end-of-line/restart sequences.
module tb_pattern_timing_gen;

  localparam int LINE_LEN    = 4;
  localparam int FRAME_LINES = 2;
  localparam int COL_W       = 10;
  localparam int ROW_W       = 9;

  logic             clk;
  logic             rst_n;
  logic             sync;
  logic             f_sync;
  logic             cnt_enb;
  logic [1:0]       X;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             active, newLine, endLine, endFrame, cb_phase, sync_err;

  pattern_timing_gen #(
    .LINE_LEN(LINE_LEN), .FRAME_LINES(FRAME_LINES), .COL_W(COL_W), .ROW_W(ROW_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sync(sync), .f_sync(f_sync), .cnt_enb(cnt_enb), .X(X),
    .col(col), .row(row), .active(active), .newLine(newLine), .endLine(endLine),
    .endFrame(endFrame), .cb_phase(cb_phase), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r, s, f, e;
    logic [1:0] x;
    int         col, row;
    logic       act, nl, el, ef, cb, er;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input logic r, s, f, e, input logic [1:0] x, input int c, rw,
                     input logic a, nl, el, ef, cb, er);
    vec_t v;
    v.r = r; v.s = s; v.f = f; v.e = e; v.x = x; v.col = c; v.row = rw;
    v.act = a; v.nl = nl; v.el = el; v.ef = ef; v.cb = cb; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act_v, input int exp_v);
    tests++;
    if (act_v != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
    end
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic [COL_W+ROW_W+5:0] got, want;
    got  = {col, row, active, newLine, endLine, endFrame, cb_phase, sync_err};
    want = {COL_W'(v.col), ROW_W'(v.row), v.act, v.nl, v.el, v.ef, v.cb, v.er};
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL vec%0d: got col=%0d row=%0d act/nl/el/ef/cb/err=%b%b%b%b%b%b expected col=%0d row=%0d act/nl/el/ef/cb/err=%b%b%b%b%b%b",
               idx, col, row, active, newLine, endLine, endFrame, cb_phase, sync_err,
               v.col, v.row, v.act, v.nl, v.el, v.ef, v.cb, v.er);
    end
  endtask

  task automatic drive(input logic r, s, f, e, input logic [1:0] x);
    @(negedge clk);
    rst_n = r; sync = s; f_sync = f; cnt_enb = e; X = x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; sync = 1'b0; f_sync = 1'b0; cnt_enb = 1'b0; X = 2'd0;

    //   r  s  f  e  x   col row act nl el ef cb err
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);   // reset
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);   // IDLE holds
    add(0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);   // -> WAIT_FRAME
    add(0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);   // f_sync -> WAIT_LINE
    add(0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0);   // line 0, X=0
    add(0, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0,  2, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0,  3, 0, 1, 0, 1, 0, 1, 0);
    add(0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0,  0, 1, 1, 1, 0, 0, 1, 0);   // line 1, X=0
    add(0, 0, 0, 1, 0,  1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0,  2, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0,  3, 1, 1, 0, 1, 1, 0, 0);   // endLine+endFrame
    add(0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);   // -> WAIT_FRAME
    add(0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);   // sync ignored
    add(0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0);   // stall line
    add(0, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0,  2, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  2, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  2, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  2, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0,  3, 0, 1, 0, 1, 0, 1, 0);
    add(0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 1,  0, 1, 1, 1, 0, 0, 0, 0);   // line 1, X=1
    add(0, 0, 0, 1, 1,  1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1,  2, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1,  3, 1, 1, 0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 1,  0, 0, 1, 1, 0, 0, 0, 0);   // line 0, X=1
    add(0, 0, 0, 1, 1,  1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1,  2, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1,  3, 0, 1, 0, 1, 0, 1, 0);
    add(0, 0, 0, 1, 1,  0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 1,  0, 1, 1, 1, 0, 0, 0, 0);   // violation: sync at col 1
    add(0, 0, 0, 1, 1,  1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 1,  0, 1, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1,  1, 1, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1);   // f_sync mid-line
    add(0, 1, 0, 1, 1,  0, 0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1,  1, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1,  2, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 1,  3, 0, 1, 0, 1, 0, 1, 1);
    add(0, 0, 0, 1, 1,  0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 1, 1,  0, 1, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1,  1, 1, 1, 0, 0, 0, 0, 1);
    add(0, 1, 1, 1, 1,  0, 0, 1, 1, 0, 0, 0, 1);   // f_sync+sync in ACTIVE
    add(0, 0, 0, 1, 1,  1, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1,  2, 0, 1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0);   // reset mid-line
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);   // ignored in IDLE
    add(0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0);   // f_sync on row 0: no error
    add(0, 1, 0, 1, 1,  0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1,  1, 0, 1, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].r; sync = vecs[i].s; f_sync = vecs[i].f;
      cnt_enb = vecs[i].e; X = vecs[i].x;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      check_vec(i, exp_q.pop_front());
    end

    // Run to the end of the current line within a bounded number of cycles.
    begin
      bit found;
      found = 1'b0;
      for (int n = 0; n < 8 && !found; n++) begin
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
        if (endLine) found = 1'b1;
      end
      chk("endline_seen", int'(found), 1);
      chk("endline_col", int'(col), LINE_LEN - 1);
      chk("endline_row", int'(row), 0);
      chk("endline_no_frame", int'(endFrame), 0);
    end

    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    chk("after_line_active", int'(active), 0);
    chk("after_line_row", int'(row), 1);

    // f_sync+sync while waiting on row 1: restart counts as a violation.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2'd1);
    chk("wl_restart_row", int'(row), 0);
    chk("wl_restart_col", int'(col), 0);
    chk("wl_restart_newline", int'(newLine), 1);
    chk("wl_restart_err", int'(sync_err), 1);

    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    chk("err_sticky", int'(sync_err), 1);
    chk("advance_col", int'(col), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pattern_timing_gen.md
Name: pattern_timing_gen

Overview:
- Timing stage that sits beside the pattern Control FSM.
- Consumes sync, f_sync, cnt_enb and X; produces the endLine/endFrame pulses that Control consumes, plus the pixel column/row position and the checkerboard cell parity used by the pattern datapath.
- Every output is registered.

Parameters:
LINE_LEN, 640, active pixels per line (>=2)
FRAME_LINES, 480, active lines per frame (>=2)
COL_W, 10, column counter width, 2^COL_W >= LINE_LEN
ROW_W, 9, row counter width, 2^ROW_W >= FRAME_LINES

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-high: 1 = reset
sync  in  1  line-start pulse, one cycle
f_sync  in  1  frame-start pulse, one cycle
cnt_enb  in  1  count enable from Control; 0 = stall/hold
X  in  2  checkerboard cell size select, cell = 2^X pixels
col  out  COL_W  current pixel column
row  out  ROW_W  current line index
active  out  1  col/row hold a valid active pixel
newLine  out  1  one-cycle pulse on the first pixel of each line
endLine  out  1  one-cycle pulse with the last pixel of a line
endFrame  out  1  one-cycle pulse with the last pixel of a frame
cb_phase  out  1  checkerboard parity of the current pixel
sync_err  out  1  sticky flag for a protocol violation

Behaviour:
- Reset (rst_n=1 at a clock edge):
  - state=IDLE.
  - col=0, row=0, active=0, newLine=0, endLine=0, endFrame=0, cb_phase=0, sync_err=0.
  - Reset asserted mid-line aborts the line immediately. No end pulses are emitted.
- Inputs are sampled at edge N; the resulting outputs are visible after edge N. Latency is 1 cycle.
- State machine (IDLE, WAIT_FRAME, WAIT_LINE, ACTIVE):
  - IDLE: stays in IDLE while cnt_enb=0. When cnt_enb=1, goes to WAIT_FRAME. sync and f_sync are ignored in IDLE.
  - WAIT_FRAME: on f_sync, row=0 and go to WAIT_LINE. sync is ignored.
  - WAIT_LINE: on sync, col=0, active=1, newLine=1, go to ACTIVE.
  - ACTIVE with cnt_enb=1: col increments by 1 each cycle.
  - ACTIVE with cnt_enb=0: col, row and active hold, and no pulses are generated.
- Line end (entering the cycle in which col==LINE_LEN-1 with cnt_enb=1):
  - endLine=1 for exactly that displayed pixel.
  - On the next advance: active=0 and col=0.
  - If row<FRAME_LINES-1: row increments and go to WAIT_LINE.
  - Otherwise: endFrame=1 together with endLine on the last pixel, row=0, go to WAIT_FRAME.
- f_sync in WAIT_LINE or ACTIVE restarts the frame: row=0, col=0, active=0, go to WAIT_LINE.
  - If this occurs in ACTIVE, or in WAIT_LINE with row!=0, set sync_err.
- sync in ACTIVE restarts the line: col=0, newLine=1, row unchanged, sync_err=1.
- f_sync and sync in the same cycle (WAIT_FRAME, WAIT_LINE or ACTIVE): the frame restart takes priority, then the line starts in the same cycle. Result: row=0, col=0, active=1, newLine=1, state=ACTIVE.
- sync_err is cleared only by reset.
- cb_phase = col[X] XOR row[X], computed from the next col/row values so that it aligns with col/row. cb_phase=0 when active=0. A change on X takes effect at the next pixel.
- newLine, endLine and endFrame are never asserted while active=0, except that endLine/endFrame are asserted on the last active pixel.

Decomposition:
- Shared package pattern_pkg holds:
  - State encodings: IDLE=0, WAIT_FRAME=1, WAIT_LINE=2, ACTIVE=3.
  - Mode encodings shared with Control.
  - X cell-size constants.
- One natural sub-module: pos_counter. It is a single parameterised wrap counter with clear, enable and terminal-count outputs, instantiated once for col and once for row.

Test Plan:
(All scenarios use LINE_LEN=4, FRAME_LINES=2.)
- Reset, then cnt_enb=1, f_sync, then sync 2 cycles later:
  - col runs 0,1,2,3.
  - newLine at col=0.
  - endLine at col=3.
  - row 0→1 after the line.
  - Second sync yields endLine and endFrame together on row=1, col=3; state returns to WAIT_FRAME.
- Stall: cnt_enb=0 for 3 cycles at col=2:
  - col holds at 2.
  - No endLine during the stall.
  - Resumes to 3 with endLine when cnt_enb returns to 1.
- Violation: sync at col=1 in ACTIVE → col=0, newLine=1, row unchanged, sync_err=1 and stays set. f_sync mid-line → row=0, active=0.
- Simultaneous f_sync and sync while in ACTIVE on row=1 → next cycle row=0, col=0, active=1, newLine=1.
- Checkerboard: X=0 gives cb_phase 0,1,0,1 on row 0 and 1,0,1,0 on row 1. X=1 gives 0,0,1,1 on both rows 0 and 1.
- Reset asserted mid-line at col=2 → all outputs 0 next cycle, state IDLE; nothing advances until cnt_enb=1 and f_sync.
